// File: rtl/store_buffer.sv
// Store buffer: holds executed stores until ROB commit, drains committed
// entries to data memory in FIFO order, and flags loads hitting a buffered word.
module store_buffer #(
   parameter int STORE_BUFFER_SIZE = 4,
   parameter int IDX_W = $clog2(STORE_BUFFER_SIZE)
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         alloc_valid_i,
   input  logic [31:0]                  alloc_addr_i,
   input  logic [31:0]                  alloc_data_i,
   input  logic [1:0]                   alloc_size_i,
   output logic [IDX_W-1:0]             alloc_idx_o,
   output logic                         full_o,
   output logic                         empty_o,
   input  logic                         commit_valid_i,
   input  logic                         commit_store_i,
   input  logic [IDX_W-1:0]             commit_idx_i,
   input  logic [STORE_BUFFER_SIZE-1:0] discard_i,
   output logic                         mem_req_valid_o,
   output logic [31:0]                  mem_req_addr_o,
   output logic [31:0]                  mem_req_data_o,
   output logic [1:0]                   mem_req_size_o,
   input  logic                         mem_req_ready_i,
   input  logic [31:0]                  ld_addr_i,
   output logic                         ld_conflict_o
);

   localparam int N  = STORE_BUFFER_SIZE;
   localparam int CW = IDX_W + 1;

   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_PEND = 2'd1,
      ST_COMM = 2'd2
   } st_e;

   st_e         state_q [N];
   st_e         state_d [N];
   logic [31:0] addr_q  [N];
   logic [31:0] addr_d  [N];
   logic [31:0] data_q  [N];
   logic [31:0] data_d  [N];
   logic [1:0]  size_q  [N];
   logic [1:0]  size_d  [N];

   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   logic alloc_ok;
   logic drain_ok;
   logic unused_ld_lsb;

   assign unused_ld_lsb = ^ld_addr_i[1:0];

   always_comb begin
      full_o          = (count_q == CW'(N));
      empty_o         = (count_q == '0);
      alloc_idx_o     = tail_q;
      mem_req_valid_o = (state_q[head_q] == ST_COMM);
      mem_req_addr_o  = '0;
      mem_req_data_o  = '0;
      mem_req_size_o  = '0;
      if (mem_req_valid_o) begin
         mem_req_addr_o = addr_q[head_q];
         mem_req_data_o = data_q[head_q];
         mem_req_size_o = size_q[head_q];
      end
      ld_conflict_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (state_q[i] != ST_FREE &&
             addr_q[i][31:2] == ld_addr_i[31:2]) begin
            ld_conflict_o = 1'b1;
         end
      end
   end

   always_comb begin
      alloc_ok = alloc_valid_i && !full_o && (discard_i == '0);
      drain_ok = mem_req_valid_o && mem_req_ready_i;
      head_d   = head_q + IDX_W'(drain_ok);
      count_d  = '0;
      for (int i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         addr_d[i]  = addr_q[i];
         data_d[i]  = data_q[i];
         size_d[i]  = size_q[i];
         // commit takes priority over a discard of the same entry
         if (state_q[i] == ST_PEND) begin
            if (commit_valid_i && commit_store_i &&
                commit_idx_i == IDX_W'(i)) begin
               state_d[i] = ST_COMM;
            end else if (discard_i[i]) begin
               state_d[i] = ST_FREE;
            end
         end
         if (drain_ok && head_q == IDX_W'(i)) begin
            state_d[i] = ST_FREE;
         end
         if (alloc_ok && tail_q == IDX_W'(i)) begin
            state_d[i] = ST_PEND;
            addr_d[i]  = alloc_addr_i;
            data_d[i]  = alloc_data_i;
            size_d[i]  = alloc_size_i;
         end
         if (state_d[i] != ST_FREE) begin
            count_d = count_d + CW'(1);
         end
      end
      // survivors are contiguous from the head, so tail follows from count
      tail_d = head_d + count_d[IDX_W-1:0];
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= ST_FREE;
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
            size_q[i]  <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            addr_q[i]  <= addr_d[i];
            data_q[i]  <= data_d[i];
            size_q[i]  <= size_d[i];
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic checked
// against a queue-based model of the buffered stores.
module tb_store_buffer;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        alloc_valid_i;
   logic [31:0] alloc_addr_i;
   logic [31:0] alloc_data_i;
   logic [1:0]  alloc_size_i;
   logic [1:0]  alloc_idx_o;
   logic        full_o;
   logic        empty_o;
   logic        commit_valid_i;
   logic        commit_store_i;
   logic [1:0]  commit_idx_i;
   logic [3:0]  discard_i;
   logic        mem_req_valid_o;
   logic [31:0] mem_req_addr_o;
   logic [31:0] mem_req_data_o;
   logic [1:0]  mem_req_size_o;
   logic        mem_req_ready_i;
   logic [31:0] ld_addr_i;
   logic        ld_conflict_o;

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   store_buffer #(.STORE_BUFFER_SIZE(4)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .alloc_valid_i(alloc_valid_i), .alloc_addr_i(alloc_addr_i),
      .alloc_data_i(alloc_data_i), .alloc_size_i(alloc_size_i),
      .alloc_idx_o(alloc_idx_o), .full_o(full_o), .empty_o(empty_o),
      .commit_valid_i(commit_valid_i), .commit_store_i(commit_store_i),
      .commit_idx_i(commit_idx_i), .discard_i(discard_i),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
      .mem_req_data_o(mem_req_data_o), .mem_req_size_o(mem_req_size_o),
      .mem_req_ready_i(mem_req_ready_i), .ld_addr_i(ld_addr_i),
      .ld_conflict_o(ld_conflict_o)
   );

   // model: buffered stores oldest first, plus the slot index of the oldest
   typedef struct {
      int          idx;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  sz;
      bit          comm;
   } ent_t;

   ent_t mq[$];
   int   mhead = 0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic idle();
      alloc_valid_i   = 1'b0;
      alloc_addr_i    = '0;
      alloc_data_i    = '0;
      alloc_size_i    = '0;
      commit_valid_i  = 1'b0;
      commit_store_i  = 1'b0;
      commit_idx_i    = '0;
      discard_i       = '0;
      mem_req_ready_i = 1'b0;
   endtask

   task automatic check_model();
      bit vld;
      bit conf;
      vld  = mq.size() > 0 && mq[0].comm;
      conf = 1'b0;
      foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr_i[31:2]) conf = 1'b1;
      chk("m_idx", 32'(alloc_idx_o), 32'((mhead + mq.size()) % 4));
      chk("m_full", 32'(full_o), 32'(mq.size() == 4));
      chk("m_empty", 32'(empty_o), 32'(mq.size() == 0));
      chk("m_valid", 32'(mem_req_valid_o), 32'(vld));
      chk("m_ldc", 32'(ld_conflict_o), 32'(conf));
      if (vld) begin
         chk("m_addr", mem_req_addr_o, mq[0].addr);
         chk("m_data", mem_req_data_o, mq[0].data);
         chk("m_size", 32'(mem_req_size_o), 32'(mq[0].sz));
      end
   endtask

   task automatic model_update();
      bit   fire;
      bit   acc;
      int   nidx;
      ent_t e;
      ent_t keep[$];
      fire = mq.size() > 0 && mq[0].comm && mem_req_ready_i;
      acc  = alloc_valid_i && mq.size() < 4 && discard_i == 4'b0;
      nidx = (mhead + mq.size()) % 4;
      if (commit_valid_i && commit_store_i)
         foreach (mq[i]) if (mq[i].idx == int'(commit_idx_i)) mq[i].comm = 1'b1;
      foreach (mq[i]) if (mq[i].comm || !discard_i[mq[i].idx]) keep.push_back(mq[i]);
      mq = keep;
      if (fire) begin
         void'(mq.pop_front());
         mhead = (mhead + 1) % 4;
      end
      if (acc) begin
         e.idx  = nidx;
         e.addr = alloc_addr_i;
         e.data = alloc_data_i;
         e.sz   = alloc_size_i;
         e.comm = 1'b0;
         mq.push_back(e);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
      #1 check_model();
      @(posedge clk_i);
      model_update();
      #1;
   endtask

   task automatic reset_lits();
      chk("r_idx", 32'(alloc_idx_o), 32'd0);
      chk("r_full", 32'(full_o), 32'd0);
      chk("r_empty", 32'(empty_o), 32'd1);
      chk("r_valid", 32'(mem_req_valid_o), 32'd0);
      chk("r_addr", mem_req_addr_o, 32'd0);
      chk("r_data", mem_req_data_o, 32'd0);
      chk("r_size", 32'(mem_req_size_o), 32'd0);
      chk("r_ldc", 32'(ld_conflict_o), 32'd0);
   endtask

   task automatic do_reset();
      #2 rstn_i = 1'b0;
      idle();
      mq.delete();
      mhead = 0;
      #1 reset_lits();
      @(posedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic alloc(input logic [31:0] a, input logic [31:0] d);
      idle();
      alloc_valid_i = 1'b1;
      alloc_addr_i  = a;
      alloc_data_i  = d;
      alloc_size_i  = 2'b10;
      step();
   endtask

   task automatic commit(input logic [1:0] idx);
      idle();
      commit_valid_i = 1'b1;
      commit_store_i = 1'b1;
      commit_idx_i   = idx;
      step();
   endtask

   task automatic drain1();
      idle();
      mem_req_ready_i = 1'b1;
      step();
   endtask

   task automatic rand_cycle();
      int   np;
      int   fp;
      int   k;
      logic [3:0] pm;
      idle();
      np = 0;
      fp = -1;
      pm = '0;
      foreach (mq[i]) if (!mq[i].comm) begin
         np++;
         pm[mq[i].idx] = 1'b1;
         if (fp < 0) fp = i;
      end
      alloc_valid_i  = 1'($urandom % 2);
      alloc_addr_i   = 32'h1000 + 32'($urandom_range(0, 7) * 4)
                       + 32'($urandom_range(0, 3));
      alloc_data_i   = $urandom;
      alloc_size_i   = 2'($urandom % 4);
      commit_valid_i = 1'($urandom % 2);
      commit_store_i = ($urandom % 5) != 0;
      commit_idx_i   = (fp >= 0) ? 2'(mq[fp].idx) : 2'($urandom % 4);
      if ($urandom % 8 == 0) begin
         discard_i = 4'($urandom) & ~pm;
         if (np > 0) begin
            k = $urandom_range(1, np);
            for (int j = mq.size() - k; j < mq.size(); j++)
               discard_i[mq[j].idx] = 1'b1;
         end
      end
      mem_req_ready_i = ($urandom % 5) < 3;
      ld_addr_i = 32'h1000 + 32'($urandom_range(0, 9) * 4)
                  + 32'($urandom_range(0, 3));
      step();
   endtask

   initial begin
      rstn_i    = 1'b0;
      ld_addr_i = '0;
      idle();
      @(posedge clk_i);
      #1 do_reset();

      // single store round trip
      chk("t1_idx0", 32'(alloc_idx_o), 32'd0);
      alloc(32'h100, 32'hDEADBEEF);
      commit(2'd0);
      chk("t1_valid", 32'(mem_req_valid_o), 32'd1);
      chk("t1_addr", mem_req_addr_o, 32'h100);
      chk("t1_data", mem_req_data_o, 32'hDEADBEEF);
      drain1();
      chk("t1_empty", 32'(empty_o), 32'd1);

      // fill, reject, drain in order, wrap
      do_reset();
      for (int k = 0; k < 4; k++) alloc(32'h40 + 32'(k * 4), 32'(k));
      chk("t2_full", 32'(full_o), 32'd1);
      alloc(32'h999, 32'h9);
      chk("t2_full2", 32'(full_o), 32'd1);
      for (int k = 0; k < 4; k++) commit(2'(k));
      for (int k = 0; k < 4; k++) begin
         chk("t2_vld", 32'(mem_req_valid_o), 32'd1);
         chk("t2_ord", mem_req_addr_o, 32'h40 + 32'(k * 4));
         drain1();
      end
      chk("t2_empty", 32'(empty_o), 32'd1);
      chk("t2_wrap", 32'(alloc_idx_o), 32'd0);

      // discard of younger pending entries
      do_reset();
      for (int k = 0; k < 3; k++) alloc(32'h80 + 32'(k * 4), 32'(k));
      commit(2'd0);
      idle();
      discard_i = 4'b0110;
      step();
      chk("t3_idx", 32'(alloc_idx_o), 32'd1);
      chk("t3_vld", 32'(mem_req_valid_o), 32'd1);
      chk("t3_addr", mem_req_addr_o, 32'h80);
      drain1();
      chk("t3_empty", 32'(empty_o), 32'd1);
      chk("t3_idx2", 32'(alloc_idx_o), 32'd1);

      // commit beats discard on the same entry
      do_reset();
      alloc(32'h300, 32'h3);
      alloc(32'h304, 32'h4);
      commit(2'd0);
      idle();
      commit_valid_i = 1'b1;
      commit_store_i = 1'b1;
      commit_idx_i   = 2'd1;
      discard_i      = 4'b0010;
      step();
      drain1();
      chk("t4_vld", 32'(mem_req_valid_o), 32'd1);
      chk("t4_addr", mem_req_addr_o, 32'h304);
      drain1();
      chk("t4_empty", 32'(empty_o), 32'd1);

      // load conflict at word granularity
      do_reset();
      alloc(32'h200, 32'h7);
      ld_addr_i = 32'h202;
      #1 chk("t5_hit", 32'(ld_conflict_o), 32'd1);
      ld_addr_i = 32'h204;
      #1 chk("t5_miss", 32'(ld_conflict_o), 32'd0);
      commit(2'd0);
      drain1();
      ld_addr_i = 32'h202;
      #1 chk("t5_gone", 32'(ld_conflict_o), 32'd0);

      // stalled request stays stable, then reset mid-hold
      do_reset();
      alloc(32'h500, 32'h55);
      commit(2'd0);
      for (int k = 0; k < 5; k++) begin
         idle();
         step();
         chk("t6_vld", 32'(mem_req_valid_o), 32'd1);
         chk("t6_addr", mem_req_addr_o, 32'h500);
         chk("t6_data", mem_req_data_o, 32'h55);
      end
      do_reset();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom % 400 == 0) do_reset();
         else rand_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
